// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame-based debounce; drives calculator button levels.
// Latency: key_code updates one cycle after debounce settles, decoded levels and strobe one cycle later.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] push,
  output logic       plus,
  output logic       minus,
  output logic       equal,
  output logic       ce,
  output logic [3:0] key_code,
  output logic       key_strobe
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [3:0]    NONE       = 4'd15;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DB_ONE     = CW'(1);

  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    row;
  logic [1:0]    hit_cnt;
  logic [3:0]    hit_code;
  logic [3:0]    prev;
  logic [CW-1:0] db_cnt;
  logic [3:0]    shown;

  logic [1:0] row_hits;
  logic [3:0] row_code;
  logic [2:0] tot;
  logic [1:0] merged;
  logic [3:0] frame_code;
  logic       last_dwell;

  function automatic logic [3:0] key_map(input logic [3:0] pos);
    case (pos)
      4'd0:  key_map = 4'd1;
      4'd1:  key_map = 4'd2;
      4'd2:  key_map = 4'd3;
      4'd3:  key_map = 4'd10;
      4'd4:  key_map = 4'd4;
      4'd5:  key_map = 4'd5;
      4'd6:  key_map = 4'd6;
      4'd7:  key_map = 4'd11;
      4'd8:  key_map = 4'd7;
      4'd9:  key_map = 4'd8;
      4'd10: key_map = 4'd9;
      4'd11: key_map = 4'd12;
      4'd12: key_map = 4'd13;
      4'd13: key_map = 4'd0;
      default: key_map = NONE;
    endcase
  endfunction

  // Hit count saturates at 2: any multi-key frame is rejected outright.
  always_comb begin
    row_hits = 2'd0;
    row_code = NONE;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_code = key_map({row, 2'(c)});
      end
    end
    tot        = {1'b0, hit_cnt} + {1'b0, row_hits};
    merged     = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    frame_code = (tot == 3'd1) ? ((hit_cnt == 2'd1) ? hit_code : row_code) : NONE;
    last_dwell = (dwell == DWELL_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_s1     <= 4'b1111;
      col_s2     <= 4'b1111;
      dwell      <= '0;
      row        <= 2'd0;
      row_n      <= 4'b1110;
      hit_cnt    <= 2'd0;
      hit_code   <= NONE;
      prev       <= NONE;
      db_cnt     <= '0;
      key_code   <= NONE;
      shown      <= NONE;
      key_strobe <= 1'b0;
      push       <= '0;
      plus       <= 1'b0;
      minus      <= 1'b0;
      equal      <= 1'b0;
      ce         <= 1'b0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (last_dwell) begin
        dwell <= '0;
        row   <= row + 2'd1;
        row_n <= {row_n[2:0], row_n[3]};
        if (row == 2'd3) begin
          hit_cnt  <= 2'd0;
          hit_code <= NONE;
          if (frame_code == prev) begin
            if (db_cnt != DB_MAX) db_cnt <= db_cnt + DB_ONE;
          end else begin
            db_cnt <= DB_ONE;
            prev   <= frame_code;
          end
        end else begin
          hit_cnt <= merged;
          if (hit_cnt == 2'd0 && row_hits == 2'd1) hit_code <= row_code;
        end
      end else begin
        dwell <= dwell + DWELL_ONE;
      end

      if (db_cnt == DB_MAX && prev != key_code) key_code <= prev;

      // Levels and strobe follow key_code by one cycle so they switch together.
      shown      <= key_code;
      key_strobe <= (key_code != shown) && (key_code != NONE);
      push       <= (key_code <= 4'd9) ? (10'd1 << key_code) : 10'd0;
      plus       <= (key_code == 4'd10);
      minus      <= (key_code == 4'd11);
      equal      <= (key_code == 4'd12);
      ce         <= (key_code == 4'd13);
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: frame-level reference model feeds an expectation queue, a monitor checks it.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 4 * SD;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [9:0] push;
  logic       plus, minus, equal, ce;
  logic [3:0] key_code;
  logic       key_strobe;

  logic [15:0] pressed = '0;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int n_strobe_seen = 0;
  int n_strobe_exp = 0;

  typedef struct {
    int code;
    int at;
  } exp_t;
  exp_t exp_q[$];
  int   hist[$];
  int   accepted = 15;
  int   kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 13, 0, 15, 15};

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .RST(RST), .col_n(col_n), .row_n(row_n), .push(push),
    .plus(plus), .minus(minus), .equal(equal), .ce(ce),
    .key_code(key_code), .key_strobe(key_strobe)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Physical matrix: a held key pulls its column low only while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int i = 0; i < 16; i++)
      if (pressed[i] && !row_n[i/4]) col_n[i%4] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  function automatic logic [14:0] levels(input int code);
    logic [9:0] p;
    p = (code <= 9) ? (10'd1 << code) : 10'd0;
    return {p, code == 10, code == 11, code == 12, code == 13, code != 15};
  endfunction

  function automatic int ref_code(input logic [15:0] m);
    if ($countones(m) != 1) return 15;
    for (int i = 0; i < 16; i++) if (m[i]) return kmap[i];
    return 15;
  endfunction

  // Hold a key set for one full frame; a key is accepted once the last DB frames all agree on it.
  task automatic run_frame(input logic [15:0] m);
    int fc;
    bit agree;
    exp_t e;
    pressed = m;
    fc = ref_code(m);
    hist.push_back(fc);
    if (hist.size() > DB) void'(hist.pop_front());
    agree = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != fc) agree = 0;
    if (agree && fc != accepted) begin
      accepted = fc;
      e.code = fc;
      e.at = cyc + FRAME + 1;
      exp_q.push_back(e);
      if (fc != 15) n_strobe_exp++;
    end
    repeat (FRAME) @(posedge CLK);
    #1;
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    hist.delete();
    exp_q.delete();
    accepted = 15;
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 15);
    check("rst_levels", {push, plus, minus, equal, ce, key_strobe}, 15'd0);
    RST = 1'b0;
  endtask

  function automatic logic [15:0] k(input int idx);
    logic [15:0] one;
    one = 16'd1;
    return one << idx;
  endfunction

  int  last_seen = 15;
  bit  pend = 0;
  int  pend_code = 15;

  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      last_seen = 15;
      pend = 0;
    end else begin
      if (key_strobe) n_strobe_seen++;
      if (pend) begin
        check("levels_after_change", {push, plus, minus, equal, ce, key_strobe}, levels(pend_code));
        pend = 0;
      end
      if (key_code !== 4'(last_seen)) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: key_code=%0d with no change expected at cycle %0d", key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          check("key_code", key_code, e.code);
          check("accept_cycle", cyc, e.at);
        end
        pend = 1;
        pend_code = int'(key_code);
        last_seen = int'(key_code);
      end
    end
  end

  initial begin
    logic [15:0] cur;
    int r;
    @(posedge CLK);
    #1;
    do_reset();

    // '5' press and release, then bounce
    frames(k(5), 6);
    frames(16'd0, 5);
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? k(5) : 16'd0);
    frames(16'd0, 4);

    // '1'+'2' rejected, then '1' alone
    frames(k(0) | k(1), 5);
    frames(k(0), 4);
    frames(16'd0, 4);

    // '+', '0', '=', 'CE' in turn
    frames(k(3), 5);
    frames(k(13), 5);
    frames(k(11), 5);
    frames(k(12), 5);
    frames(16'd0, 4);

    // '7' interrupted by a mid-frame reset
    frames(k(8), 2);
    repeat (5) @(posedge CLK);
    #1;
    do_reset();
    frames(k(8), 5);
    frames(16'd0, 4);

    // unused matrix position
    frames(k(14), 5);
    frames(16'd0, 2);

    cur = '0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 5 || r == 6 || r == 9) cur = k($urandom_range(0, 15));
      else if (r == 7) cur = '0;
      else if (r == 8) cur = k($urandom_range(0, 7)) | k($urandom_range(8, 15));
      run_frame(cur);
    end
    frames(16'd0, 5);
    repeat (4) @(posedge CLK);
    #1;

    check("pending_expectations", exp_q.size(), 0);
    check("strobe_count", n_strobe_seen, n_strobe_exp);
    check("final_key_code", key_code, 15);
    check("final_levels", {push, plus, minus, equal, ce, key_strobe}, 15'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
